// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM input-capture block.
// Holds the FSM state encoding, register word addresses and register bit positions.
package pwm_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CFG    = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CFG_EN      = 0;
  localparam int CFG_ONESHOT = 1;
  localparam int CFG_SEL_LSB = 4;
  localparam int CFG_INV     = 7;
  localparam int CFG_PSC_LSB = 8;
  localparam int CFG_IE      = 16;

  localparam int STAT_DONE  = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_LEVEL = 3;

endpackage

// File: rtl/pwm_cap_if.sv
// 32-bit register bus shared with the PWM blocks.
// Handshake: reg_ack pulses for one cycle after reg_cs is seen with reg_ack low; reg_rdata is valid only with reg_ack.
interface pwm_cap_if;
  logic        reg_cs;
  logic        reg_wr;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/pwm_cap_sync.sv
// Multi-stage input synchroniser followed by a rise/fall detector.
// Edges are reported combinationally against the previous synchronised sample.
module pwm_cap_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic mclk,
  input  logic h_reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STG-1:0] sync_q;
  logic                prev_q;

  always_ff @(posedge mclk) begin
    if (!h_reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], din};
      prev_q <= sync_q[SYNC_STG-1];
    end
  end

  assign level = sync_q[SYNC_STG-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Single-channel PWM input capture: measures high time and period of a selected pad
// in prescaled ticks and reports them over the register bus with an interrupt.
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic           mclk,
  input  logic           h_reset_n,
  pwm_cap_if.slave       bus,
  input  logic [7:0]     pad_gpio,
  output logic           cap_intr,
  output state_e         dbg_state
);

  logic             cfg_en, cfg_oneshot, cfg_inv, cfg_ie;
  logic [2:0]       cfg_sel;
  logic [7:0]       cfg_psc, pcnt;
  logic [CNT_W-1:0] cnt, hi_tmp, high_r, period_r;
  logic             done, ovf;
  state_e           state, state_nxt;

  logic level, rise, fall, tick, busy, access, wr_en, w1c;
  logic cnt_clr, cnt_one, cnt_inc, hi_ld, res_ld, done_set, ovf_set, en_clr;
  logic [31:0] rd_val;
  logic unused_bits;

  pwm_cap_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .mclk      (mclk),
    .h_reset_n (h_reset_n),
    .din       (pad_gpio[cfg_sel] ^ cfg_inv),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  assign access      = bus.reg_cs & ~bus.reg_ack;
  assign wr_en       = access & bus.reg_wr;
  assign w1c         = wr_en & (bus.reg_addr == ADDR_STATUS) & bus.reg_be[0];
  assign tick        = (pcnt == cfg_psc);
  assign busy        = (state == ST_MEAS_HIGH) || (state == ST_MEAS_LOW);
  assign dbg_state   = state;
  assign unused_bits = ^{bus.reg_wdata[31:17], bus.reg_wdata[3], bus.reg_be[3]};

  always_ff @(posedge mclk) begin
    if (!h_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Overflow is checked before edges so a saturated count never produces a result.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_one   = 1'b0;
    cnt_inc   = 1'b0;
    hi_ld     = 1'b0;
    res_ld    = 1'b0;
    done_set  = 1'b0;
    ovf_set   = 1'b0;
    en_clr    = 1'b0;
    if (!cfg_en) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_clr   = 1'b1;
          state_nxt = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            cnt_one   = 1'b1;
            state_nxt = ST_MEAS_HIGH;
          end
        end
        ST_MEAS_HIGH: begin
          if (&cnt) begin
            ovf_set   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ST_WAIT_RISE;
          end else begin
            cnt_inc = tick;
            if (fall) begin
              hi_ld     = 1'b1;
              state_nxt = ST_MEAS_LOW;
            end
          end
        end
        ST_MEAS_LOW: begin
          if (&cnt) begin
            ovf_set   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = ST_WAIT_RISE;
          end else if (rise) begin
            res_ld   = 1'b1;
            done_set = 1'b1;
            cnt_one  = 1'b1;
            if (cfg_oneshot) begin
              en_clr    = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_MEAS_HIGH;
            end
          end else begin
            cnt_inc = tick;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (!h_reset_n) begin
      pcnt     <= '0;
      cnt      <= '0;
      hi_tmp   <= '0;
      high_r   <= '0;
      period_r <= '0;
    end else begin
      if (!cfg_en || rise || tick) pcnt <= '0;
      else                         pcnt <= pcnt + 8'd1;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_one) cnt <= CNT_W'(1);
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (hi_ld) hi_tmp <= cnt;
      if (res_ld) begin
        high_r   <= hi_tmp;
        period_r <= cnt;
      end
    end
  end

  // Hardware clear of en is applied after the bus write so a oneshot completion always wins.
  always_ff @(posedge mclk) begin
    if (!h_reset_n) begin
      cfg_en      <= 1'b0;
      cfg_oneshot <= 1'b0;
      cfg_sel     <= '0;
      cfg_inv     <= 1'b0;
      cfg_psc     <= '0;
      cfg_ie      <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      cap_intr    <= 1'b0;
    end else begin
      if (wr_en && bus.reg_addr == ADDR_CFG) begin
        if (bus.reg_be[0]) begin
          cfg_en      <= bus.reg_wdata[CFG_EN];
          cfg_oneshot <= bus.reg_wdata[CFG_ONESHOT];
          cfg_sel     <= bus.reg_wdata[CFG_SEL_LSB +: 3];
          cfg_inv     <= bus.reg_wdata[CFG_INV];
        end
        if (bus.reg_be[1]) cfg_psc <= bus.reg_wdata[CFG_PSC_LSB +: 8];
        if (bus.reg_be[2]) cfg_ie  <= bus.reg_wdata[CFG_IE];
      end
      if (en_clr) cfg_en <= 1'b0;
      done     <= done_set | (done & ~(w1c & bus.reg_wdata[STAT_DONE]));
      ovf      <= ovf_set  | (ovf  & ~(w1c & bus.reg_wdata[STAT_OVF]));
      cap_intr <= cfg_ie & (done | ovf);
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus.reg_addr)
      ADDR_CFG: begin
        rd_val[CFG_EN]             = cfg_en;
        rd_val[CFG_ONESHOT]        = cfg_oneshot;
        rd_val[CFG_SEL_LSB +: 3]   = cfg_sel;
        rd_val[CFG_INV]            = cfg_inv;
        rd_val[CFG_PSC_LSB +: 8]   = cfg_psc;
        rd_val[CFG_IE]             = cfg_ie;
      end
      ADDR_HIGH:   rd_val[CNT_W-1:0] = high_r;
      ADDR_PERIOD: rd_val[CNT_W-1:0] = period_r;
      ADDR_STATUS: begin
        rd_val[STAT_DONE]  = done;
        rd_val[STAT_OVF]   = ovf;
        rd_val[STAT_BUSY]  = busy;
        rd_val[STAT_LEVEL] = level;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!h_reset_n) begin
      bus.reg_ack   <= 1'b0;
      bus.reg_rdata <= '0;
    end else begin
      bus.reg_ack   <= access;
      bus.reg_rdata <= (access && !bus.reg_wr) ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: bus access, capture, prescaler/invert,
// overflow, W1C collision, oneshot and abort scenarios.
module tb_pwm_capture;
  import pwm_cap_pkg::*;

  localparam int CNT_W    = 8;
  localparam int SYNC_STG = 2;

  logic       mclk = 1'b0;
  logic       h_reset_n = 1'b0;
  logic [7:0] pad_gpio = 8'h00;
  logic       cap_intr;
  state_e     dbg_state;

  pwm_cap_if bus ();

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STG(SYNC_STG)) dut (
    .mclk      (mclk),
    .h_reset_n (h_reset_n),
    .bus       (bus),
    .pad_gpio  (pad_gpio),
    .cap_intr  (cap_intr),
    .dbg_state (dbg_state)
  );

  always #5 mclk = ~mclk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd, exp_v;
  logic        ak;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic bus_idle();
    bus.reg_cs    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 32'd0;
    bus.reg_be    = 4'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.reg_cs = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = a; bus.reg_wdata = d; bus.reg_be = be;
    @(posedge mclk); #1;
    bus_idle();
    @(posedge mclk); #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic ack);
    bus.reg_cs = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = a;
    @(posedge mclk); #1;
    d   = bus.reg_rdata;
    ack = bus.reg_ack;
    bus_idle();
    @(posedge mclk); #1;
  endtask

  task automatic pad_hold(input int idx, input logic v, input int n);
    pad_gpio[idx] = v;
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic apply_reset();
    bus_idle();
    pad_gpio  = 8'h00;
    h_reset_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    h_reset_n = 1'b1;
    @(posedge mclk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus_idle();
    h_reset_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    checks++; if (bus.reg_rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", bus.reg_rdata); end
    checks++; if (bus.reg_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b exp=0", bus.reg_ack); end
    checks++; if (cap_intr !== 1'b0) begin failures++; $display("FAIL rst_intr got=%0b exp=0", cap_intr); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    h_reset_n = 1'b1;
    @(posedge mclk); #1;
    for (int a = 0; a < 4; a++) begin
      exp_q.push_back(32'd0);
      bus_read(a[1:0], rd, ak);
      exp_v = exp_q.pop_front();
      checks++; if (rd !== exp_v || ak !== 1'b1) begin failures++; $display("FAIL rst_reg%0d got=%0h ack=%0b exp=%0h", a, rd, ak, exp_v); end
    end
    // Byte enables: only the psc byte lands.
    bus_write(ADDR_CFG, 32'hFFFF_FFFF, 4'b0010);
    exp_q.push_back(32'h0000_FF00);
    bus_read(ADDR_CFG, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL be_cfg got=%0h exp=%0h", rd, exp_v); end
    // Read-only result register ignores writes.
    bus_write(ADDR_HIGH, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'd0);
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v || ak !== 1'b1) begin failures++; $display("FAIL ro_high got=%0h ack=%0b exp=%0h", rd, ak, exp_v); end
    // Full CFG write masks reserved bits; cs held two cycles gives a one-cycle ack.
    bus_write(ADDR_CFG, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'h0001_FFF3);
    bus.reg_cs = 1'b1; bus.reg_wr = 1'b0; bus.reg_addr = ADDR_CFG;
    @(posedge mclk); #1;
    exp_v = exp_q.pop_front();
    checks++; if (bus.reg_ack !== 1'b1 || bus.reg_rdata !== exp_v) begin failures++; $display("FAIL ack_first ack=%0b got=%0h exp=%0h", bus.reg_ack, bus.reg_rdata, exp_v); end
    @(posedge mclk); #1;
    checks++; if (bus.reg_ack !== 1'b0 || bus.reg_rdata !== 32'd0) begin failures++; $display("FAIL ack_width ack=%0b got=%0h exp=0", bus.reg_ack, bus.reg_rdata); end
    bus_idle();
    @(posedge mclk); #1;
  endtask

  task automatic test_basic();
    apply_reset();
    bus_write(ADDR_CFG, 32'h0001_0001, 4'hF);
    pad_hold(0, 1'b1, 30);
    pad_hold(0, 1'b0, 70);
    pad_gpio[0] = 1'b1;
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd100);
    exp_q.push_back(32'h0000_000D);
    repeat (3) @(posedge mclk);
    #1;
    checks++; if (cap_intr !== 1'b0) begin failures++; $display("FAIL basic_intr_early got=%0b exp=0", cap_intr); end
    @(posedge mclk); #1;
    checks++; if (cap_intr !== 1'b1) begin failures++; $display("FAIL basic_intr got=%0b exp=1", cap_intr); end
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL basic_high got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_PERIOD, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL basic_period got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL basic_status got=%0h exp=%0h", rd, exp_v); end
    bus_write(ADDR_CFG, 32'd0, 4'hF);
  endtask

  task automatic test_prescale_invert();
    apply_reset();
    bus_write(ADDR_CFG, 32'h0000_03B1, 4'hF);
    pad_hold(3, 1'b1, 20);
    pad_hold(3, 1'b0, 40);
    pad_hold(3, 1'b1, 60);
    pad_gpio[3] = 1'b0;
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd25);
    exp_q.push_back(32'h0000_000D);
    exp_q.push_back(32'h0000_03B1);
    repeat (6) @(posedge mclk);
    #1;
    checks++; if (cap_intr !== 1'b0) begin failures++; $display("FAIL psc_intr_masked got=%0b exp=0", cap_intr); end
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL psc_high got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_PERIOD, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL psc_period got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL psc_status got=%0h exp=%0h", rd, exp_v); end
    bus_read(ADDR_CFG, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL psc_cfg got=%0h exp=%0h", rd, exp_v); end
  endtask

  task automatic test_overflow();
    apply_reset();
    bus_write(ADDR_CFG, 32'h0001_0001, 4'hF);
    pad_gpio[0] = 1'b1;
    exp_q.push_back(32'h0000_000A);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    // Rise acts 2 edges after the pad change; count saturates 255 ticks later, intr one edge after that.
    repeat (258) @(posedge mclk);
    #1;
    checks++; if (cap_intr !== 1'b0) begin failures++; $display("FAIL ovf_intr_early got=%0b exp=0", cap_intr); end
    @(posedge mclk); #1;
    checks++; if (cap_intr !== 1'b1) begin failures++; $display("FAIL ovf_intr got=%0b exp=1", cap_intr); end
    checks++; if (dbg_state !== ST_WAIT_RISE) begin failures++; $display("FAIL ovf_state got=%0d exp=%0d", dbg_state, ST_WAIT_RISE); end
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL ovf_status got=%0h exp=%0h", rd, exp_v); end
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL ovf_high got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_PERIOD, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL ovf_period got=%0d exp=%0d", rd, exp_v); end
  endtask

  task automatic test_w1c_collision();
    apply_reset();
    bus_write(ADDR_CFG, 32'h0000_0001, 4'hF);
    pad_hold(0, 1'b1, 20);
    pad_hold(0, 1'b0, 30);
    pad_gpio[0] = 1'b1;
    exp_q.push_back(32'h0000_000D);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd50);
    exp_q.push_back(32'h0000_000C);
    repeat (2) @(posedge mclk);
    #1;
    // Commit lands on the same edge the capture completes.
    bus.reg_cs = 1'b1; bus.reg_wr = 1'b1; bus.reg_addr = ADDR_STATUS; bus.reg_wdata = 32'h1; bus.reg_be = 4'hF;
    @(posedge mclk); #1;
    bus_idle();
    @(posedge mclk); #1;
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL w1c_collide got=%0h exp=%0h", rd, exp_v); end
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL w1c_high got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_PERIOD, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL w1c_period got=%0d exp=%0d", rd, exp_v); end
    bus_write(ADDR_STATUS, 32'h1, 4'hF);
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL w1c_clear got=%0h exp=%0h", rd, exp_v); end
    bus_write(ADDR_CFG, 32'd0, 4'hF);
  endtask

  task automatic test_oneshot();
    apply_reset();
    bus_write(ADDR_CFG, 32'h0000_0003, 4'hF);
    pad_hold(0, 1'b1, 20);
    pad_hold(0, 1'b0, 30);
    pad_hold(0, 1'b1, 10);
    pad_hold(0, 1'b0, 15);
    pad_hold(0, 1'b1, 12);
    pad_gpio[0] = 1'b0;
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd50);
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h0000_0001);
    repeat (5) @(posedge mclk);
    #1;
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL os_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL os_high got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_PERIOD, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL os_period got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_CFG, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL os_cfg got=%0h exp=%0h", rd, exp_v); end
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL os_status got=%0h exp=%0h", rd, exp_v); end
  endtask

  task automatic test_abort();
    apply_reset();
    bus_write(ADDR_CFG, 32'h0000_0001, 4'hF);
    pad_hold(0, 1'b1, 20);
    pad_hold(0, 1'b0, 30);
    pad_hold(0, 1'b1, 10);
    pad_gpio[0] = 1'b0;
    exp_q.push_back(32'h0000_0005);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd50);
    repeat (8) @(posedge mclk);
    #1;
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL abort_busy got=%0h exp=%0h", rd, exp_v); end
    bus_write(ADDR_CFG, 32'd0, 4'hF);
    bus_read(ADDR_STATUS, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL abort_status got=%0h exp=%0h", rd, exp_v); end
    bus_read(ADDR_HIGH, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL abort_high got=%0d exp=%0d", rd, exp_v); end
    bus_read(ADDR_PERIOD, rd, ak);
    exp_v = exp_q.pop_front();
    checks++; if (rd !== exp_v) begin failures++; $display("FAIL abort_period got=%0d exp=%0d", rd, exp_v); end
  endtask

  initial begin
    bus_idle();
    #1;
    test_reset();
    test_basic();
    test_prescale_invert();
    test_overflow();
    test_w1c_collision();
    test_oneshot();
    test_abort();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Single-channel PWM input capture: the receive-side counterpart to the PWM waveform generators in the PWM subsystem.
- Selects one pad_gpio bit and synchronises it. Measures high time and period in prescaled mclk ticks, then presents the results on the same 32-bit register bus used by the PWM blocks.
- Raises an interrupt on capture-done or counter overflow. Instantiated beside pwm_top; its address decode lives in the peripheral wrapper.

Parameters:
- CNT_W, 16, width of the high and period counters and result registers (8..24).
- SYNC_STG, 2, input synchroniser depth (>=2).

Ports:
- mclk  input  1  system clock
- h_reset_n  input  1  reset, synchronous to mclk, active low
- reg_cs  input  1  register select
- reg_wr  input  1  1=write, 0=read
- reg_addr  input  2  word address: 0=CFG, 1=HIGH, 2=PERIOD, 3=STATUS
- reg_wdata  input  32  write data
- reg_be  input  4  byte enables for writes
- reg_rdata  output  32  read data, registered
- reg_ack  output  1  one-cycle access acknowledge
- pad_gpio  input  8  candidate capture inputs
- cap_intr  output  1  level interrupt

Behaviour:
- Reset: synchronous on the mclk edge with h_reset_n=0. All registers and the FSM clear; reg_rdata=0, reg_ack=0, cap_intr=0.
- Bus handshake:
  - reg_ack=1 in the cycle after reg_cs=1 && reg_ack=0; it is always exactly one cycle wide.
  - Writes commit on the edge that raises reg_ack; only bytes with reg_be set are written.
  - reg_rdata is valid with reg_ack and 0 otherwise.
- CFG register (RW):
  - [0] en
  - [1] oneshot
  - [6:4] sel (pad_gpio index)
  - [7] inv (invert input)
  - [15:8] psc
  - [16] ie
  - Other bits read 0.
- HIGH/PERIOD (RO, CNT_W LSBs, upper bits 0): last completed measurement. Writes are ignored but still acked.
- STATUS register:
  - [0] done (W1C)
  - [1] ovf (W1C)
  - [2] busy (RO, FSM in MEAS_HIGH or MEAS_LOW)
  - [3] level (RO, synchronised, inverted input)
- Input path: pad_gpio[sel] ^ inv, then SYNC_STG flops, then edge detect against the previous sample. An edge is therefore seen SYNC_STG+1 cycles after the pad change.
- Tick: prescaler counts 0..psc and ticks when it equals psc. It is cleared on every detected rise. With psc=0, every cycle is a tick.
- FSM:
  - IDLE: en=0. Counters clear. Go to WAIT_RISE when en=1.
  - WAIT_RISE: on a rise, cnt<=1 and go to MEAS_HIGH. A level already high at enable is not a rise.
  - MEAS_HIGH: cnt increments on each tick. On a fall, hi_tmp<=cnt (before increment) and go to MEAS_LOW.
  - MEAS_LOW: cnt increments on each tick. On a rise:
    - HIGH<=hi_tmp, PERIOD<=cnt, done<=1, cnt<=1, stay measuring (go to MEAS_HIGH).
    - If oneshot=1: clear en in hardware and go to IDLE instead.
- Result with psc=0: input high H cycles and low L cycles gives HIGH=H and PERIOD=H+L.
- Overflow: if cnt reaches all-ones in MEAS_HIGH or MEAS_LOW, set ovf, go to WAIT_RISE, leave HIGH/PERIOD unchanged, no done.
- en cleared by software mid-measurement: IDLE on the next cycle; partial data discarded; results and status kept.
- cfg change while en=1 (sel, inv, psc): the software contract is to disable first. The hardware does not restart the measurement automatically.
- Simultaneous events: a hardware set of done/ovf wins over a same-cycle W1C of that bit. HIGH and PERIOD update together, atomically.
- cap_intr = ie & (done | ovf), registered (one-cycle latency).

Decomposition:
- pwm_cap_pkg holds:
  - FSM state enum
  - register address constants
  - CFG/STATUS bit-position localparams
- Natural sub-module: pwm_cap_sync (parameterised SYNC_STG synchroniser plus rise/fall detector), reusable by future gpio capture.

Test Plan:
- Reset: hold h_reset_n=0 for 3 cycles -> reg_rdata=0, reg_ack=0, cap_intr=0; all registers read 0 after release.
- Basic capture: CFG=0x0001_0001 (en, ie, sel 0, psc 0); drive pad_gpio[0] with 30 high / 70 low -> after the second rise, HIGH=30, PERIOD=100, STATUS.done=1, cap_intr=1 one cycle later.
- Prescaler and invert: sel=3, inv=1, psc=3; drive pad_gpio[3] with 40 low / 60 high -> HIGH=10, PERIOD=25.
- Overflow: CNT_W=8; input stuck high after a rise -> ovf=1 at cnt=255, no done, busy=0.
- W1C collision: write STATUS=0x1 in the same cycle a new capture completes -> done reads 1.
- Oneshot and abort: oneshot=1 -> exactly one capture, then CFG.en reads 0. Separately, clear en mid-MEAS_LOW -> busy=0 next cycle and the prior HIGH/PERIOD are retained.
